rf_fill_arbiter: RTL and testbench
==================================

# rf_fill_arbiter

Shares the single data-memory read port among NCORES register-file entries that are waiting on a retrieval (the `retr` state of a register-file entry). Selects one pending core round-robin, issues one memory read for that core's tag, and broadcasts the returned value as a fill (core, tag, value) to the register file. Every core waiting on the same tag is satisfied by that one fill. Sits between the per-core register-file lookup logic and the memory port, parallel to the write-back path.

## Interface
- NCORES, 4, number of cores / register-file entries (≥2); CW = clog2(NCORES)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NCORES  bit i high: entry i is valid, not locked, awaiting retrieval
- req_tag  in  NCORES*16  tag of entry i at bits [i*16 +: 16]
- mem_rd_req  out  1  memory read request, held until accepted
- mem_addr  out  16  read address (tag of the granted core)
- mem_rd_ack  in  1  memory accepted the request this cycle
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  16  read data
- fill_valid  out  1  one-cycle fill pulse
- fill_core  out  CW  core that won arbitration for this fill
- fill_tag  out  16  tag being filled
- fill_val  out  16  value being filled
- fill_mask  out  NCORES  entries satisfied by this fill; they must drop req next cycle
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, FILL.
- IDLE:
  - If req ≠ 0, pick the first set bit scanning from last_grant+1 upward, with wrap.
  - Latch the winner's index into cur_core and its req_tag into cur_tag; go to ISSUE.
  - If req = 0, stay in IDLE.
- ISSUE:
  - mem_rd_req = 1 and mem_addr = cur_tag, both stable until acked.
  - On mem_rd_ack, go to WAIT.
  - If mem_rd_ack and mem_rd_valid arrive in the same cycle, latch mem_rd_data and go straight to FILL.
- WAIT:
  - On mem_rd_valid, latch mem_rd_data into cur_val and go to FILL.
  - mem_rd_valid is ignored in IDLE and FILL.
  - mem_rd_valid is ignored in ISSUE unless mem_rd_ack is also high.
- FILL, exactly one cycle:
  - fill_valid = 1; fill_core = cur_core; fill_tag = cur_tag; fill_val = cur_val.
  - fill_mask[i] = req[i] && req_tag[i] == cur_tag. This is combinational from the current inputs.
  - last_grant <= cur_core; go to IDLE.
- Requester withdrawal: if req[cur_core] drops after grant, the transaction still completes. fill_mask may then be all-zero. No abort.
- Duplicate tags: only one memory read per arbitration. Other cores with an equal tag appear in fill_mask and are not granted separately.
- A core's req changing in ISSUE or WAIT does not change cur_tag.
- Fairness: a core with continuous req is granted within NCORES arbitrations.

## Timing
- Reset (asynchronous, rst_n low), effective immediately:
  - State goes to IDLE.
  - mem_rd_req, fill_valid and busy = 0; fill_mask = 0.
  - mem_addr, fill_core, fill_tag, fill_val = 0.
  - last_grant = NCORES-1, so core 0 has first priority.
- Reset mid-transaction drops the in-flight read. A late mem_rd_valid arriving after reset is ignored because the FSM is in IDLE.
- mem_rd_req, mem_addr and the fill_* data outputs are driven from registers or state; only fill_mask is combinational.
- Latency:
  - Cycle n: req sampled in IDLE.
  - n+1: ISSUE, mem_rd_req high.
  - n+2: FILL at the earliest, when ack and valid both come in cycle n+1.
  - Generally fill occurs the cycle after mem_rd_valid.
- Throughput: a new arbitration starts the cycle after FILL. Minimum 3 cycles per fill; IDLE is one cycle when req is pending.
- busy is high from the cycle after the grant until FILL, inclusive.

## Test plan
- Reset, then req=0001, req_tag[0]=0x0010, memory acks and returns 0x00AB in the same cycle:
  - mem_rd_req with mem_addr=0x0010 the cycle after req.
  - Next cycle: fill_valid with fill_core=0, fill_tag=0x0010, fill_val=0x00AB, fill_mask=0001.
- req=1111 held (tags 0x1,0x2,0x3,0x4, distinct): grants in order 0,1,2,3,0, each producing exactly one memory read with the matching address.
- req=0101, both tags 0x0020, read returns 0x0005: exactly one mem_rd_req; fill_core=0, fill_mask=0101.
- ack in cycle k, valid delayed 5 cycles: mem_rd_req deasserts after ack; fill_valid fires exactly one cycle after mem_rd_valid; busy stays high throughout.
- Granted core 2 drops req during WAIT: fill still occurs with fill_core=2 and fill_mask=0000; the next arbitration starts from core 3.
- rst_n low during WAIT, then mem_rd_valid arrives after release: all outputs go to 0 immediately; no fill_valid; the first post-reset grant goes to the lowest pending core.

Source files
------------

// File: rtl/rf_fill_arbiter.sv
// Round-robin arbiter that shares one memory read port among register-file
// entries waiting on a retrieval, and broadcasts each returned value as a fill.
module rf_fill_arbiter #(
  parameter int NCORES = 4,
  localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCORES-1:0]  req,
  input  logic [NCORES*16-1:0] req_tag,
  output logic               mem_rd_req,
  output logic [15:0]        mem_addr,
  input  logic               mem_rd_ack,
  input  logic               mem_rd_valid,
  input  logic [15:0]        mem_rd_data,
  output logic               fill_valid,
  output logic [CW-1:0]      fill_core,
  output logic [15:0]        fill_tag,
  output logic [15:0]        fill_val,
  output logic [NCORES-1:0]  fill_mask,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FILL} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cur_core, last_grant, pick_idx, cand;
  logic [15:0]   cur_tag, cur_val;
  logic          pick_found, load_grant, load_val;
  logic [15:0]   tags [NCORES];

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      tags[i] = req_tag[i*16 +: 16];
    end
  end

  // Scan upward from the core after the last grant so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NCORES; k++) begin
      cand = CW'((int'(last_grant) + k) % NCORES);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    load_val   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          load_grant = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rd_ack) begin
          if (mem_rd_valid) begin
            load_val   = 1'b1;
            state_next = FILL;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rd_valid) begin
          load_val   = 1'b1;
          state_next = FILL;
        end
      end
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The tag is captured at grant time, so later req changes cannot disturb the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_core   <= '0;
      cur_tag    <= '0;
      cur_val    <= '0;
      last_grant <= CW'(NCORES - 1);
    end else begin
      if (load_grant) begin
        cur_core <= pick_idx;
        cur_tag  <= tags[pick_idx];
      end
      if (load_val) cur_val <= mem_rd_data;
      if (state == FILL) last_grant <= cur_core;
    end
  end

  assign mem_rd_req = (state == ISSUE);
  assign mem_addr   = (state == ISSUE) ? cur_tag : 16'h0;
  assign fill_valid = (state == FILL);
  assign fill_core  = (state == FILL) ? cur_core : '0;
  assign fill_tag   = (state == FILL) ? cur_tag : 16'h0;
  assign fill_val   = (state == FILL) ? cur_val : 16'h0;
  assign busy       = (state != IDLE);

  // Every entry still waiting on the same tag is satisfied by this one fill.
  always_comb begin
    fill_mask = '0;
    if (state == FILL) begin
      for (int i = 0; i < NCORES; i++) begin
        fill_mask[i] = req[i] && (tags[i] == cur_tag);
      end
    end
  end

endmodule

// File: tb/tb_rf_fill_arbiter.sv
// Directed self-checking bench for rf_fill_arbiter; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_rf_fill_arbiter;
  localparam int NCORES = 4;
  localparam int CW = 2;

  logic clk, rst_n;
  logic [NCORES-1:0] req;
  logic [NCORES*16-1:0] req_tag;
  logic mem_rd_req, mem_rd_ack, mem_rd_valid;
  logic [15:0] mem_addr, mem_rd_data;
  logic fill_valid, busy;
  logic [CW-1:0] fill_core;
  logic [15:0] fill_tag, fill_val;
  logic [NCORES-1:0] fill_mask;

  int n_tests = 0;
  int n_fail = 0;

  rf_fill_arbiter #(.NCORES(NCORES)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_tag(req_tag),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .fill_valid(fill_valid), .fill_core(fill_core), .fill_tag(fill_tag),
    .fill_val(fill_val), .fill_mask(fill_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0; req_tag = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; req_tag = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    #3;
    n_tests++; if ({mem_rd_req, fill_valid, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ctrl got %b exp 000", {mem_rd_req, fill_valid, busy}); end
    n_tests++; if (fill_mask !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_mask got %b exp 0000", fill_mask); end
    n_tests++; if ({mem_addr, fill_tag, fill_val} !== 48'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h exp 0", {mem_addr, fill_tag, fill_val}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001; req_tag[15:0] = 16'h0010;
    step();
    n_tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("[TB] FAIL single_issue got req=%b addr=%h exp 1/0010", mem_rd_req, mem_addr); end
    mem_rd_ack = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'h00AB;
    step();
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
    n_tests++; if (fill_valid !== 1'b1 || fill_core !== 2'd0) begin n_fail++; $display("[TB] FAIL single_fill got v=%b core=%0d exp 1/0", fill_valid, fill_core); end
    n_tests++; if (fill_tag !== 16'h0010 || fill_val !== 16'h00AB) begin n_fail++; $display("[TB] FAIL single_data got tag=%h val=%h exp 0010/00ab", fill_tag, fill_val); end
    n_tests++; if (fill_mask !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_mask got %b exp 0001", fill_mask); end
    n_tests++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("[TB] FAIL single_req_drop got %b exp 0", mem_rd_req); end
    req = 4'b0000;
    step();
    n_tests++; if (fill_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle got v=%b busy=%b exp 0/0", fill_valid, busy); end
  endtask

  task automatic test_round_robin();
    int exp_core [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = 4'b1111;
    req_tag = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    for (int n = 0; n < 5; n++) begin
      step();
      n_tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 16'(exp_core[n] + 1)) begin n_fail++; $display("[TB] FAIL rr_addr[%0d] got req=%b addr=%h exp 1/%h", n, mem_rd_req, mem_addr, exp_core[n] + 1); end
      mem_rd_ack = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'(16'h0100 + n);
      step();
      mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
      n_tests++; if (fill_valid !== 1'b1 || fill_core !== CW'(exp_core[n]) || fill_val !== 16'(16'h0100 + n)) begin n_fail++; $display("[TB] FAIL rr_fill[%0d] got v=%b core=%0d val=%h exp 1/%0d/%h", n, fill_valid, fill_core, fill_val, exp_core[n], 16'h0100 + n); end
      n_tests++; if (fill_mask !== (4'b0001 << exp_core[n])) begin n_fail++; $display("[TB] FAIL rr_mask[%0d] got %b exp %b", n, fill_mask, 4'b0001 << exp_core[n]); end
      step();
      n_tests++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_idle[%0d] got req=%b busy=%b exp 0/0", n, mem_rd_req, busy); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_duplicate();
    apply_reset();
    req = 4'b0101;
    req_tag = {16'h0000, 16'h0020, 16'h0000, 16'h0020};
    step();
    n_tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0020) begin n_fail++; $display("[TB] FAIL dup_issue got req=%b addr=%h exp 1/0020", mem_rd_req, mem_addr); end
    mem_rd_ack = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'h0005;
    step();
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
    n_tests++; if (fill_core !== 2'd0 || fill_val !== 16'h0005) begin n_fail++; $display("[TB] FAIL dup_fill got core=%0d val=%h exp 0/0005", fill_core, fill_val); end
    n_tests++; if (fill_mask !== 4'b0101) begin n_fail++; $display("[TB] FAIL dup_mask got %b exp 0101", fill_mask); end
    req = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      step();
      n_tests++; if (mem_rd_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL dup_second_read[%0d] got req=%b busy=%b exp 0/0", n, mem_rd_req, busy); end
    end
  endtask

  task automatic test_delayed_valid();
    apply_reset();
    req = 4'b0010;
    req_tag = {16'h0000, 16'h0000, 16'h0033, 16'h0000};
    step();
    mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD;
    step();
    mem_rd_valid = 1'b0;
    n_tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0033 || fill_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dly_hold got req=%b addr=%h v=%b exp 1/0033/0", mem_rd_req, mem_addr, fill_valid); end
    mem_rd_ack = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      n_tests++; if (mem_rd_req !== 1'b0 || busy !== 1'b1 || fill_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dly_wait[%0d] got req=%b busy=%b v=%b exp 0/1/0", n, mem_rd_req, busy, fill_valid); end
      step();
    end
    mem_rd_valid = 1'b1; mem_rd_data = 16'h0077;
    n_tests++; if (fill_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL dly_early got v=%b busy=%b exp 0/1", fill_valid, busy); end
    step();
    mem_rd_valid = 1'b0;
    n_tests++; if (fill_valid !== 1'b1 || fill_core !== 2'd1 || fill_val !== 16'h0077 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL dly_fill got v=%b core=%0d val=%h busy=%b exp 1/1/0077/1", fill_valid, fill_core, fill_val, busy); end
    n_tests++; if (fill_mask !== 4'b0010) begin n_fail++; $display("[TB] FAIL dly_mask got %b exp 0010", fill_mask); end
    req = 4'b0000;
    step();
    n_tests++; if (fill_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dly_pulse got %b exp 0", fill_valid); end
  endtask

  task automatic test_withdraw();
    apply_reset();
    req = 4'b0100;
    req_tag = {16'h0000, 16'h0044, 16'h0000, 16'h0000};
    step();
    mem_rd_ack = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    req = 4'b1001;
    req_tag = {16'h0060, 16'h0044, 16'h0000, 16'h0050};
    mem_rd_valid = 1'b1; mem_rd_data = 16'h0099;
    step();
    mem_rd_valid = 1'b0;
    n_tests++; if (fill_valid !== 1'b1 || fill_core !== 2'd2 || fill_tag !== 16'h0044 || fill_val !== 16'h0099) begin n_fail++; $display("[TB] FAIL wd_fill got v=%b core=%0d tag=%h val=%h exp 1/2/0044/0099", fill_valid, fill_core, fill_tag, fill_val); end
    n_tests++; if (fill_mask !== 4'b0000) begin n_fail++; $display("[TB] FAIL wd_mask got %b exp 0000", fill_mask); end
    step();
    step();
    n_tests++; if (mem_rd_req !== 1'b1 || mem_addr !== 16'h0060) begin n_fail++; $display("[TB] FAIL wd_next got req=%b addr=%h exp 1/0060", mem_rd_req, mem_addr); end
    mem_rd_ack = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'h0011;
    step();
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
    n_tests++; if (fill_core !== 2'd3 || fill_mask !== 4'b1000) begin n_fail++; $display("[TB] FAIL wd_next_fill got core=%0d mask=%b exp 3/1000", fill_core, fill_mask); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0110;
    req_tag = {16'h0000, 16'h0072, 16'h0071, 16'h0000};
    step();
    n_tests++; if (mem_addr !== 16'h0071) begin n_fail++; $display("[TB] FAIL rm_grant got addr=%h exp 0071", mem_addr); end
    mem_rd_ack = 1'b1;
    step();
    mem_rd_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({mem_rd_req, fill_valid, busy} !== 3'b000 || fill_mask !== 4'b0000) begin n_fail++; $display("[TB] FAIL rm_ctrl got %b mask=%b exp 000/0000", {mem_rd_req, fill_valid, busy}, fill_mask); end
    n_tests++; if ({mem_addr, fill_tag, fill_val, 14'(fill_core)} !== 62'h0) begin n_fail++; $display("[TB] FAIL rm_data got %h exp 0", {mem_addr, fill_tag, fill_val, 14'(fill_core)}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_data = 16'h00EE;
    step();
    mem_rd_valid = 1'b0;
    n_tests++; if (fill_valid !== 1'b0 || mem_rd_req !== 1'b1 || mem_addr !== 16'h0071) begin n_fail++; $display("[TB] FAIL rm_post got v=%b req=%b addr=%h exp 0/1/0071", fill_valid, mem_rd_req, mem_addr); end
    mem_rd_ack = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = 16'h0022;
    step();
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0;
    n_tests++; if (fill_core !== 2'd1 || fill_val !== 16'h0022 || fill_mask !== 4'b0010) begin n_fail++; $display("[TB] FAIL rm_fill got core=%0d val=%h mask=%b exp 1/0022/0010", fill_core, fill_val, fill_mask); end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_duplicate();
    test_delayed_valid();
    test_withdraw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
